// File: rtl/exc_req_gen.sv
// exc_req_gen: CP0 exception requester.
// Arbitrates pipe exceptions and interrupts into one-cycle cp0 requests.
package exc_req_pkg;
  localparam int EXC_CODE_WIDTH = 5;
  localparam int INT_MASK_WIDTH = 8;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_INT     = 5'h00;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_SYSCALL = 5'h08;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET    = 5'h1e;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'h1f;
endpackage

module exc_req_gen
  import exc_req_pkg::*;
#(
  parameter int NR_EXT_IRQ  = 5,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_LIMIT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cp0_status,
  input  logic [31:0]               cp0_cause,
  input  logic [31:0]               cp0_count,
  input  logic [31:0]               cp0_compare,
  input  logic [NR_EXT_IRQ-1:0]     ext_irq,
  input  logic                      pipe_exc_valid,
  input  logic [EXC_CODE_WIDTH-1:0] pipe_exc_code,
  input  logic [31:0]               pipe_exc_epc,
  input  logic [31:0]               pipe_exc_badvaddr,
  output logic                      pipe_exc_ready,
  input  logic [31:0]               int_epc,
  input  logic                      int_epc_valid,
  output logic [INT_MASK_WIDTH-1:0] exc_ip,
  output logic [EXC_CODE_WIDTH-1:0] exc_code,
  output logic [31:0]               exc_epc,
  output logic [31:0]               exc_badvaddr,
  input  logic                      exc_jmp_flag,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nx;
  logic [NR_EXT_IRQ-1:0]     r_sync [SYNC_STAGES];
  logic                      r_timer_pend;
  logic [31:0]               r_prev_cmp;
  logic [CW-1:0]             r_wcnt;
  logic [CW-1:0]             w_wcnt_nx;
  logic [EXC_CODE_WIDTH-1:0] r_code;
  logic [31:0]               r_epc;
  logic [31:0]               r_bad;
  logic [INT_MASK_WIDTH-1:0] r_ip;
  logic [INT_MASK_WIDTH-1:0] w_ip;
  logic                      w_cmp_wr;
  logic                      w_int_pending;
  logic                      w_pipe_req;
  logic                      w_take_pipe;
  logic                      w_take_int;
  logic                      w_tmo_set;
  logic                      w_unused;

  assign w_unused = ^{cp0_status[31:16], cp0_status[7:2],
                      cp0_cause[31:10], cp0_cause[7:0]};

  // ext_irq synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= ext_irq;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_cmp_wr = cp0_compare != r_prev_cmp;

  // Timer pending: set on count match, cleared by a compare write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_cmp   <= '0;
      r_timer_pend <= 1'b0;
    end else begin
      r_prev_cmp <= cp0_compare;
      if (w_cmp_wr)
        r_timer_pend <= 1'b0;
      else if (cp0_count == cp0_compare)
        r_timer_pend <= 1'b1;
    end
  end

  // Assemble the pending-interrupt vector
  always_comb begin
    w_ip = '0;
    w_ip[7] = r_timer_pend;
    w_ip[2 +: NR_EXT_IRQ] = r_sync[SYNC_STAGES-1];
    w_ip[1:0] = cp0_cause[9:8];
  end

  assign w_int_pending = cp0_status[0] & ~cp0_status[1] &
                         (|(w_ip & cp0_status[15:8]));
  assign w_pipe_req = pipe_exc_valid & (pipe_exc_code != EC_NONE);

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_wcnt  <= w_wcnt_nx;
    end
  end

  // Next-state logic and request selection
  always_comb begin
    w_state_nx  = r_state;
    w_wcnt_nx   = r_wcnt;
    w_take_pipe = 1'b0;
    w_take_int  = 1'b0;
    w_tmo_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pipe_req) begin
          w_take_pipe = 1'b1;
          w_state_nx  = S_ISSUE;
        end else if (w_int_pending & int_epc_valid) begin
          w_take_int = 1'b1;
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wcnt_nx  = '0;
        w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (exc_jmp_flag) begin
          w_state_nx = S_IDLE;
        end else if (r_wcnt == LIM) begin
          w_tmo_set  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_wcnt_nx = r_wcnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Request latches and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code      <= EC_NONE;
      r_epc       <= '0;
      r_bad       <= '0;
      r_ip        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (w_take_pipe) begin
        r_code <= pipe_exc_code;
        r_epc  <= pipe_exc_epc;
        r_bad  <= pipe_exc_badvaddr;
        r_ip   <= w_ip;
      end else if (w_take_int) begin
        r_code <= EC_INT;
        r_epc  <= int_epc;
        r_bad  <= '0;
        r_ip   <= w_ip;
      end
      if (w_tmo_set) timeout_err <= 1'b1;
    end
  end

  // Drive cp0 only during the single ISSUE cycle
  always_comb begin
    exc_code       = EC_NONE;
    exc_ip         = '0;
    exc_epc        = '0;
    exc_badvaddr   = '0;
    busy           = r_state != S_IDLE;
    pipe_exc_ready = w_take_pipe & ~rst;
    if (r_state == S_ISSUE) begin
      exc_code     = r_code;
      exc_ip       = r_ip;
      exc_epc      = r_epc;
      exc_badvaddr = r_bad;
    end
  end

endmodule

// File: tb/tb_exc_req_gen.sv
// tb_exc_req_gen: directed bench for exc_req_gen.
// Hand-computed expectations per scenario task.
module tb_exc_req_gen;
  import exc_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cp0_status, cp0_cause, cp0_count, cp0_compare;
  logic [4:0]  ext_irq;
  logic        pipe_exc_valid;
  logic [4:0]  pipe_exc_code;
  logic [31:0] pipe_exc_epc, pipe_exc_badvaddr;
  logic        pipe_exc_ready;
  logic [31:0] int_epc;
  logic        int_epc_valid;
  logic [7:0]  exc_ip;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr;
  logic        exc_jmp_flag;
  logic        busy, timeout_err;

  int vecs = 0;
  int errs = 0;

  exc_req_gen #(.NR_EXT_IRQ(5), .SYNC_STAGES(2), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_count(cp0_count), .cp0_compare(cp0_compare),
    .ext_irq(ext_irq),
    .pipe_exc_valid(pipe_exc_valid), .pipe_exc_code(pipe_exc_code),
    .pipe_exc_epc(pipe_exc_epc), .pipe_exc_badvaddr(pipe_exc_badvaddr),
    .pipe_exc_ready(pipe_exc_ready),
    .int_epc(int_epc), .int_epc_valid(int_epc_valid),
    .exc_ip(exc_ip), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_jmp_flag(exc_jmp_flag),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %0b want 0", busy); end
    vecs++; if (exc_code !== EC_NONE) begin errs++; $display("FAIL rst_code got %h want %h", exc_code, EC_NONE); end
    vecs++; if (exc_ip !== 8'h00) begin errs++; $display("FAIL rst_ip got %h want 00", exc_ip); end
    vecs++; if (exc_epc !== 32'h0) begin errs++; $display("FAIL rst_epc got %h want 0", exc_epc); end
    vecs++; if (exc_badvaddr !== 32'h0) begin errs++; $display("FAIL rst_bad got %h want 0", exc_badvaddr); end
    vecs++; if (pipe_exc_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %0b want 0", pipe_exc_ready); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL rst_tmo got %0b want 0", timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_syscall();
    pipe_exc_valid = 1'b1;
    pipe_exc_code = EC_SYSCALL;
    pipe_exc_epc = 32'h8000_0100;
    pipe_exc_badvaddr = 32'h0000_1234;
    #1;
    vecs++; if (pipe_exc_ready !== 1'b1) begin errs++; $display("FAIL sys_ready got %0b want 1", pipe_exc_ready); end
    vecs++; if (exc_code !== EC_NONE) begin errs++; $display("FAIL sys_code_n got %h want %h", exc_code, EC_NONE); end
    tick();
    pipe_exc_valid = 1'b0;
    #1;
    vecs++; if (exc_code !== EC_SYSCALL) begin errs++; $display("FAIL sys_code got %h want %h", exc_code, EC_SYSCALL); end
    vecs++; if (exc_epc !== 32'h8000_0100) begin errs++; $display("FAIL sys_epc got %h want 80000100", exc_epc); end
    vecs++; if (exc_badvaddr !== 32'h0000_1234) begin errs++; $display("FAIL sys_bad got %h want 1234", exc_badvaddr); end
    vecs++; if (exc_ip !== 8'h00) begin errs++; $display("FAIL sys_ip got %h want 00", exc_ip); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL sys_busy1 got %0b want 1", busy); end
    vecs++; if (pipe_exc_ready !== 1'b0) begin errs++; $display("FAIL sys_ready0 got %0b want 0", pipe_exc_ready); end
    tick();
    vecs++; if (exc_code !== EC_NONE) begin errs++; $display("FAIL sys_code_w got %h want %h", exc_code, EC_NONE); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL sys_busy2 got %0b want 1", busy); end
    exc_jmp_flag = 1'b1;
    tick();
    exc_jmp_flag = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL sys_busy3 got %0b want 0", busy); end
  endtask

  task automatic test_none_ignored();
    pipe_exc_valid = 1'b1;
    pipe_exc_code = EC_NONE;
    #1;
    vecs++; if (pipe_exc_ready !== 1'b0) begin errs++; $display("FAIL none_ready got %0b want 0", pipe_exc_ready); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL none_busy got %0b want 0", busy); end
    pipe_exc_valid = 1'b0;
  endtask

  task automatic test_timer();
    cp0_status = 32'h0000_8001;
    cp0_compare = 32'd100;
    cp0_count = 32'd99;
    int_epc_valid = 1'b1;
    int_epc = 32'h8000_0200;
    tick();
    cp0_count = 32'd100;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL tmr_early got %0b want 0", busy); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL tmr_pend got %0b want 0", busy); end
    tick();
    vecs++; if (exc_code !== EC_INT) begin errs++; $display("FAIL tmr_code got %h want %h", exc_code, EC_INT); end
    vecs++; if (exc_ip !== 8'h80) begin errs++; $display("FAIL tmr_ip got %h want 80", exc_ip); end
    vecs++; if (exc_epc !== 32'h8000_0200) begin errs++; $display("FAIL tmr_epc got %h want 80000200", exc_epc); end
    vecs++; if (exc_badvaddr !== 32'h0) begin errs++; $display("FAIL tmr_bad got %h want 0", exc_badvaddr); end
    cp0_status = 32'h0000_8003;
    tick();
    vecs++; if (exc_code !== EC_NONE) begin errs++; $display("FAIL tmr_once got %h want %h", exc_code, EC_NONE); end
    exc_jmp_flag = 1'b1;
    tick();
    exc_jmp_flag = 1'b0;
    cp0_compare = 32'd200;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL tmr_ret got %0b want 0", busy); end
    tick();
    cp0_status = 32'h0000_8001;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL tmr_clr1 got %0b want 0", busy); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL tmr_clr2 got %0b want 0", busy); end
    cp0_status = 32'h0;
  endtask

  task automatic test_masking();
    ext_irq = 5'b00001;
    cp0_status = 32'h0000_0001;
    repeat (4) tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL msk_im got %0b want 0", busy); end
    cp0_status = 32'h0000_0403;
    repeat (2) tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL msk_exl got %0b want 0", busy); end
    ext_irq = 5'b0;
    repeat (3) tick();
    cp0_status = 32'h0000_0401;
    ext_irq = 5'b00001;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL msk_c0 got %0b want 0", busy); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL msk_c1 got %0b want 0", busy); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL msk_c2 got %0b want 0", busy); end
    tick();
    vecs++; if (exc_code !== EC_INT) begin errs++; $display("FAIL msk_code got %h want %h", exc_code, EC_INT); end
    vecs++; if (exc_ip !== 8'h04) begin errs++; $display("FAIL msk_ip got %h want 04", exc_ip); end
    cp0_status = 32'h0000_0403;
    ext_irq = 5'b0;
    tick();
    exc_jmp_flag = 1'b1;
    tick();
    exc_jmp_flag = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL msk_ret got %0b want 0", busy); end
  endtask

  task automatic test_priority();
    cp0_status = 32'h0000_0403;
    ext_irq = 5'b00001;
    repeat (3) tick();
    cp0_status = 32'h0000_0401;
    pipe_exc_valid = 1'b1;
    pipe_exc_code = EC_ERET;
    pipe_exc_epc = 32'h8000_0300;
    pipe_exc_badvaddr = 32'h0;
    #1;
    vecs++; if (pipe_exc_ready !== 1'b1) begin errs++; $display("FAIL pri_ready got %0b want 1", pipe_exc_ready); end
    tick();
    pipe_exc_valid = 1'b0;
    #1;
    vecs++; if (exc_code !== EC_ERET) begin errs++; $display("FAIL pri_eret got %h want %h", exc_code, EC_ERET); end
    vecs++; if (exc_epc !== 32'h8000_0300) begin errs++; $display("FAIL pri_epc got %h want 80000300", exc_epc); end
    tick();
    exc_jmp_flag = 1'b1;
    tick();
    exc_jmp_flag = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL pri_idle got %0b want 0", busy); end
    tick();
    vecs++; if (exc_code !== EC_INT) begin errs++; $display("FAIL pri_int got %h want %h", exc_code, EC_INT); end
    vecs++; if (exc_ip !== 8'h04) begin errs++; $display("FAIL pri_ip got %h want 04", exc_ip); end
    cp0_status = 32'h0000_0403;
    ext_irq = 5'b0;
    tick();
    exc_jmp_flag = 1'b1;
    tick();
    exc_jmp_flag = 1'b0;
    cp0_status = 32'h0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL pri_ret got %0b want 0", busy); end
  endtask

  task automatic test_timeout();
    pipe_exc_valid = 1'b1;
    pipe_exc_code = EC_SYSCALL;
    pipe_exc_epc = 32'h8000_0400;
    tick();
    pipe_exc_valid = 1'b0;
    #1;
    vecs++; if (exc_code !== EC_SYSCALL) begin errs++; $display("FAIL tmo_code got %h want %h", exc_code, EC_SYSCALL); end
    repeat (4) tick();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL tmo_busy got %0b want 1", busy); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL tmo_early got %0b want 0", timeout_err); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL tmo_idle got %0b want 0", busy); end
    vecs++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL tmo_set got %0b want 1", timeout_err); end
    exc_jmp_flag = 1'b1;
    tick();
    exc_jmp_flag = 1'b0;
    tick();
    vecs++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL tmo_sticky got %0b want 1", timeout_err); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL tmo_stale got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid_wait();
    pipe_exc_valid = 1'b1;
    pipe_exc_code = EC_SYSCALL;
    pipe_exc_epc = 32'h8000_0500;
    tick();
    pipe_exc_valid = 1'b0;
    tick();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rmw_wait got %0b want 1", busy); end
    rst = 1'b1;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmw_busy got %0b want 0", busy); end
    vecs++; if (exc_code !== EC_NONE) begin errs++; $display("FAIL rmw_code got %h want %h", exc_code, EC_NONE); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL rmw_tmo got %0b want 0", timeout_err); end
    rst = 1'b0;
    exc_jmp_flag = 1'b1;
    tick();
    exc_jmp_flag = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmw_stale got %0b want 0", busy); end
    vecs++; if (exc_code !== EC_NONE) begin errs++; $display("FAIL rmw_code2 got %h want %h", exc_code, EC_NONE); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmw_after got %0b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    cp0_status = 32'h0;
    cp0_cause = 32'h0;
    cp0_count = 32'h0;
    cp0_compare = 32'hFFFF_FFFF;
    ext_irq = 5'b0;
    pipe_exc_valid = 1'b0;
    pipe_exc_code = EC_NONE;
    pipe_exc_epc = 32'h0;
    pipe_exc_badvaddr = 32'h0;
    int_epc = 32'h0;
    int_epc_valid = 1'b0;
    exc_jmp_flag = 1'b0;
    test_reset();
    test_syscall();
    test_none_ignored();
    test_timer();
    test_masking();
    test_priority();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
